// File: rtl/mmio_uart_tx_pkg.sv
// mmio_pkg: shared UART address map, STATUS bit indices and TX state encoding
package mmio_pkg;
  localparam logic [31:0] UART_BASE_ADDR = 32'h0000_0400;
  localparam logic [31:0] STATUS_OFFSET = 32'h0000_0004;
  localparam int ST_FULL = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_ACTIVE = 2;
  localparam int ST_OVF = 3;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: core data-port bus (mem_write/data_addr/write_data in, read_data/sel out); master=core, slave=uart
interface mmio_uart_tx_if;
  logic mem_write;
  logic [31:0] data_addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic sel;
  modport master(output mem_write, data_addr, write_data, input read_data, sel);
  modport slave(input mem_write, data_addr, write_data, output read_data, sel);
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// sync_fifo: WIDTHxDEPTH FIFO with wrap-bit pointers; ports clk, rst, push, pop, din, dout (head), full, empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic do_push, do_pop;
  always_comb begin
    empty = wr_q == rd_q;
    full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d = wr_q + {{AW{1'b0}}, do_push};
    rd_d = rd_q + {{AW{1'b0}}, do_pop};
  end
  assign dout = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: MMIO 8N1 UART transmitter; ports clk, reset, bus (slave: store/load window, status read mux), tx, busy
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR = UART_BASE_ADDR
) (
  input  logic clk,
  input  logic reset,
  mmio_uart_tx_if.slave bus,
  output logic tx,
  output logic busy
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  uart_state_t state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, head;
  logic tx_q, tx_d, ovf_q, ovf_d;
  logic sel_data, sel_stat, push, clr, pop, full, empty, baud_end;
  logic [31:0] status;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(reset),
    .push(push),
    .pop(pop),
    .din(bus.write_data[7:0]),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    sel_data = bus.data_addr == BASE_ADDR;
    sel_stat = bus.data_addr == BASE_ADDR + STATUS_OFFSET;
    push = bus.mem_write && sel_data;
    clr = bus.mem_write && sel_stat && bus.write_data[0];
    baud_end = baud_q == BAUD_LAST;
    pop = !empty && (state_q == IDLE || (state_q == STOP && baud_end));
    ovf_d = (push && full && !pop) ? 1'b1 : clr ? 1'b0 : ovf_q;
    state_d = state_q;
    baud_d = baud_end ? '0 : baud_q + 1'b1;
    bit_d = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        state_d = pop ? START : IDLE;
        shift_d = pop ? head : shift_q;
      end
      START: begin
        state_d = baud_end ? DATA : START;
        bit_d = baud_end ? 3'd0 : bit_q;
      end
      DATA: if (baud_end) begin
        shift_d = shift_q >> 1;
        bit_d = bit_q + 3'd1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (baud_end) begin
        state_d = pop ? START : IDLE;
        shift_d = pop ? head : shift_q;
      end
      default: state_d = IDLE;
    endcase
    tx_d = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
    status = '0;
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
    status[ST_ACTIVE] = state_q != IDLE;
    status[ST_OVF] = ovf_q;
    bus.read_data = sel_stat ? status : '0;
    bus.sel = sel_data || sel_stat;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
      ovf_q <= ovf_d;
    end
  end
  assign tx = tx_q;
  assign busy = !empty || state_q != IDLE;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: random + directed bench against a frame-schedule reference model
module tb_mmio_uart_tx;
  import mmio_pkg::*;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
  localparam logic [31:0] BASE = UART_BASE_ADDR;
  localparam logic [31:0] STAT = UART_BASE_ADDR + 32'h4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx, busy;
  mmio_uart_tx_if bus();
  mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .tx(tx),
    .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {int pop_t; logic [7:0] d;} frame_t;
  frame_t frames[$];
  logic txlog[int];
  logic busylog[int];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic ovf_m = 1'b0;
  logic started = 1'b0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask
  function automatic int m_count(input int c);
    int n = 0;
    foreach (frames[i]) if (frames[i].pop_t > c) n++;
    return n;
  endfunction
  function automatic logic m_active(input int c);
    foreach (frames[i]) if (c >= frames[i].pop_t && c < frames[i].pop_t + FRAME) return 1'b1;
    return 1'b0;
  endfunction
  function automatic logic m_tx(input int c);
    foreach (frames[i]) begin
      int off = c - frames[i].pop_t - 1;
      if (off >= 0 && off < FRAME) begin
        int b = off / CPB;
        return b == 0 ? 1'b0 : b == 9 ? 1'b1 : frames[i].d[b-1];
      end
    end
    return 1'b1;
  endfunction
  function automatic logic [31:0] m_status(input int c);
    return {28'd0, ovf_m, m_active(c), m_count(c) == 0, m_count(c) == DEPTH};
  endfunction
  function automatic logic [9:0] decode(input int s);
    logic [9:0] v;
    for (int k = 0; k < 10; k++) v[k] = txlog[s + k * CPB + 1];
    return v;
  endfunction
  task automatic step(input logic r, input logic we, input logic [31:0] a, input logic [31:0] wd);
    logic [7:0] byte_in;
    reset = r;
    bus.mem_write = we;
    bus.data_addr = a;
    bus.write_data = wd;
    byte_in = wd[7:0];
    #1;
    if (started) begin
      chk("sel", {31'd0, bus.sel}, {31'd0, a == BASE || a == STAT});
      chk("rdata", bus.read_data, a == STAT ? m_status(cyc) : 32'd0);
    end
    @(posedge clk);
    cyc++;
    if (r) begin
      frames.delete();
      ovf_m = 1'b0;
      started = 1'b1;
    end else if (we && a == BASE) begin
      int cnt = m_count(cyc - 1);
      logic popc = 1'b0;
      foreach (frames[i]) if (frames[i].pop_t == cyc) popc = 1'b1;
      if (cnt < DEPTH || popc) begin
        int p = cyc + 1;
        if (frames.size() > 0 && frames[$].pop_t + FRAME > p) p = frames[$].pop_t + FRAME;
        frames.push_back('{p, byte_in});
      end else ovf_m = 1'b1;
    end else if (we && a == STAT && wd[0]) ovf_m = 1'b0;
    while (frames.size() > 1 && frames[0].pop_t + FRAME + 1 < cyc) void'(frames.pop_front());
    @(negedge clk);
    txlog[cyc] = tx;
    busylog[cyc] = busy;
    if (started) begin
      chk("tx", {31'd0, tx}, {31'd0, m_tx(cyc)});
      chk("busy", {31'd0, busy}, {31'd0, m_count(cyc) > 0 || m_active(cyc)});
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0);
  endtask
  initial begin
    int n;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b0, STAT, 32'd0);
    chk("rst_status", bus.read_data, 32'h2);
    chk("rst_sel", {31'd0, bus.sel}, 32'd1);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    step(1'b0, 1'b1, BASE, 32'hFFFF_FF55);
    n = cyc;
    idle(45);
    for (int k = 0; k < 10; k++) chk("b55", {31'd0, txlog[n + 3 + k * CPB]}, k % 2);
    chk("busy_end_hi", {31'd0, busylog[n + FRAME]}, 32'd1);
    chk("busy_end_lo", {31'd0, busylog[n + FRAME + 1]}, 32'd0);
    step(1'b0, 1'b1, BASE, 32'h0000_00A5);
    n = cyc;
    step(1'b0, 1'b1, BASE, 32'h1234_563C);
    idle(90);
    chk("b2b_a5", {22'd0, decode(n + 2)}, {22'd0, 1'b1, 8'hA5, 1'b0});
    chk("b2b_3c", {22'd0, decode(n + 2 + FRAME)}, {22'd0, 1'b1, 8'h3C, 1'b0});
    step(1'b0, 1'b1, BASE, 32'h11);
    idle(3);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, BASE, 32'h20 + i);
    step(1'b0, 1'b0, STAT, 32'd0);
    chk("ovf_status", bus.read_data, 32'hD);
    step(1'b0, 1'b1, STAT, 32'h1);
    step(1'b0, 1'b0, STAT, 32'd0);
    chk("clr_status", bus.read_data, 32'h5);
    idle(230);
    step(1'b0, 1'b1, BASE, 32'hC3);
    step(1'b0, 1'b1, BASE, 32'h7E);
    idle(16);
    step(1'b1, 1'b0, 32'd0, 32'd0);
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    step(1'b0, 1'b0, STAT, 32'd0);
    chk("midrst_status", bus.read_data, 32'h2);
    idle(60);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    step(1'b0, 1'b1, BASE + 32'h8, 32'hFF);
    chk("dec_sel_hi", {31'd0, bus.sel}, 32'd0);
    chk("dec_rd_hi", bus.read_data, 32'd0);
    step(1'b0, 1'b1, BASE - 32'h4, 32'hFF);
    chk("dec_sel_lo", {31'd0, bus.sel}, 32'd0);
    step(1'b0, 1'b0, STAT, 32'd0);
    chk("dec_status", bus.read_data, 32'h2);
    for (int i = 0; i < 3000; i++) begin
      int kind = $urandom_range(0, 99);
      int pp = ((i / 250) % 2) ? 30 : 3;
      logic r = $urandom_range(0, 499) == 0;
      logic [31:0] wd = $urandom;
      if (kind < pp) step(r, 1'b1, BASE, wd);
      else if (kind < pp + 3) step(r, 1'b1, STAT, wd);
      else if (kind < pp + 10) step(r, 1'b0, STAT, wd);
      else if (kind < pp + 13) step(r, 1'b1, BASE + 32'h8, wd);
      else step(r, $urandom_range(0, 1) == 1, $urandom, wd);
    end
    idle(250);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
